// File: rtl/capture_ctrl.sv
// rtl/capture_ctrl.sv - framebuffer write-port sequencer for camera capture and clear
//
// Owns the QQVGA framebuffer write port. When idle, a clear request fills every
// pixel with a constant colour. A start request arms a capture that waits for a
// VSYNC falling edge, which marks the start of a frame. During the frame, camera
// writes pass through to the framebuffer. At the VSYNC rising edge, which marks
// the end of the frame, the controller either stops or re-arms for the next frame.
//
// Optional feature macro: CAPTURE_CTRL_FRAMECHK_EN
//   Defined: counts accepted camera writes per frame and sets a sticky frame_err
//            if a frame ends with a count other than NPIX.
//   Undefined: frame_err is tied low.
//
// Ports:
//   PCLK, rst                    clock (rising edge), asynchronous active-high reset
//   VSYNC                        camera vertical sync, high between frames
//   start, stop, mode_cont       capture control pulses; mode_cont is sampled with start
//   clr_req, clr_color           clear request pulse and fill colour
//   cam_px_wr/addr/data          camera writer strobe, address and data
//   fb_wr/addr/data              registered framebuffer write port
//   busy                         high whenever not idle
//   frame_done                   one-cycle pulse at each captured frame end
//   frame_cnt                    captured frame count, wraps at 256
//   frame_err                    sticky per-frame pixel-count mismatch
module capture_ctrl #(
    parameter int AW   = 15,
    parameter int DW   = 3,
    parameter int NPIX = 19200
) (
    input  logic          PCLK,
    input  logic          rst,
    input  logic          VSYNC,
    input  logic          start,
    input  logic          stop,
    input  logic          mode_cont,
    input  logic          clr_req,
    input  logic [DW-1:0] clr_color,
    input  logic          cam_px_wr,
    input  logic [AW-1:0] cam_px_addr,
    input  logic [DW-1:0] cam_px_data,
    output logic          fb_wr,
    output logic [AW-1:0] fb_addr,
    output logic [DW-1:0] fb_data,
    output logic          busy,
    output logic          frame_done,
    output logic [7:0]    frame_cnt,
    output logic          frame_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_WAIT_VS,
        S_CAPTURE
    } state_t;

    localparam logic [AW:0] NPIX_W = (AW+1)'(NPIX);

    state_t        state_q, state_d;
    logic          vs_q;
    logic          vs_fall, vs_rise;
    logic          mode_q, mode_d;
    logic          stop_q, stop_d;
    logic [DW-1:0] color_q, color_d;
    logic [AW:0]   clr_cnt_q, clr_cnt_d;
    logic          fb_wr_q, fb_wr_d;
    logic [AW-1:0] fb_addr_q, fb_addr_d;
    logic [DW-1:0] fb_data_q, fb_data_d;
    logic          busy_q, busy_d;
    logic          frame_done_q, frame_done_d;
    logic [7:0]    frame_cnt_q, frame_cnt_d;
    logic          cam_ok;

    assign vs_fall = vs_q & ~VSYNC;
    assign vs_rise = ~vs_q & VSYNC;

    // A camera write is accepted only if its address is inside the frame.
    assign cam_ok = cam_px_wr && ({1'b0, cam_px_addr} < NPIX_W);

    always_ff @(posedge PCLK or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            vs_q         <= 1'b0;
            mode_q       <= 1'b0;
            stop_q       <= 1'b0;
            color_q      <= '0;
            clr_cnt_q    <= '0;
            fb_wr_q      <= 1'b0;
            fb_addr_q    <= '0;
            fb_data_q    <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            vs_q         <= VSYNC;
            mode_q       <= mode_d;
            stop_q       <= stop_d;
            color_q      <= color_d;
            clr_cnt_q    <= clr_cnt_d;
            fb_wr_q      <= fb_wr_d;
            fb_addr_q    <= fb_addr_d;
            fb_data_q    <= fb_data_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        stop_d       = stop_q;
        color_d      = color_q;
        clr_cnt_d    = clr_cnt_q;
        fb_wr_d      = 1'b0;
        fb_addr_d    = fb_addr_q;
        fb_data_d    = fb_data_q;
        frame_done_d = 1'b0;
        frame_cnt_d  = frame_cnt_q;

        case (state_q)
            S_IDLE: begin
                // A clear request takes priority, and a simultaneous start is dropped.
                if (clr_req) begin
                    state_d   = S_CLEAR;
                    color_d   = clr_color;
                    clr_cnt_d = '0;
                end else if (start) begin
                    state_d = S_WAIT_VS;
                    mode_d  = mode_cont;
                    stop_d  = 1'b0;
                end
            end
            S_CLEAR: begin
                // The counter runs one past the last pixel so that busy drops
                // on the cycle after the final write.
                if (clr_cnt_q == NPIX_W) begin
                    state_d = S_IDLE;
                end else begin
                    fb_wr_d   = 1'b1;
                    fb_addr_d = clr_cnt_q[AW-1:0];
                    fb_data_d = color_q;
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            S_WAIT_VS: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (vs_fall) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (cam_ok) begin
                    fb_wr_d   = 1'b1;
                    fb_addr_d = cam_px_addr;
                    fb_data_d = cam_px_data;
                end
                if (stop) begin
                    stop_d = 1'b1;
                end
                if (vs_rise) begin
                    frame_done_d = 1'b1;
                    frame_cnt_d  = frame_cnt_q + 8'd1;
                    state_d      = (mode_q && !stop_d) ? S_WAIT_VS : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

`ifdef CAPTURE_CTRL_FRAMECHK_EN
    logic [AW:0] pix_cnt_q, pix_cnt_d;
    logic [AW:0] pix_total;
    logic        err_q, err_d;

    always_ff @(posedge PCLK or posedge rst) begin
        if (rst) begin
            pix_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            pix_cnt_q <= pix_cnt_d;
            err_q     <= err_d;
        end
    end

    // The total includes a write that coincides with the frame-end edge.
    assign pix_total = pix_cnt_q + {{AW{1'b0}}, cam_ok};

    always_comb begin
        pix_cnt_d = pix_cnt_q;
        err_d     = err_q;
        case (state_q)
            S_IDLE: begin
                if (!clr_req && start) begin
                    err_d = 1'b0;
                end
            end
            S_WAIT_VS: pix_cnt_d = '0;
            S_CAPTURE: begin
                pix_cnt_d = pix_total;
                if (vs_rise && (pix_total != NPIX_W)) begin
                    err_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign frame_err = err_q;
`else
    assign frame_err = 1'b0;
`endif

    assign fb_wr      = fb_wr_q;
    assign fb_addr    = fb_addr_q;
    assign fb_data    = fb_data_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_capture_ctrl.sv
// tb/tb_capture_ctrl.sv - randomized directed bench for capture_ctrl
module tb_capture_ctrl;
    localparam int AW   = 15;
    localparam int DW   = 3;
    localparam int NPIX = 19200;

    logic          PCLK = 1'b0;
    logic          rst;
    logic          VSYNC;
    logic          start;
    logic          stop;
    logic          mode_cont;
    logic          clr_req;
    logic [DW-1:0] clr_color;
    logic          cam_px_wr;
    logic [AW-1:0] cam_px_addr;
    logic [DW-1:0] cam_px_data;
    logic          fb_wr;
    logic [AW-1:0] fb_addr;
    logic [DW-1:0] fb_data;
    logic          busy;
    logic          frame_done;
    logic [7:0]    frame_cnt;
    logic          frame_err;

    int         checks  = 0;
    int         errors  = 0;
    logic [7:0] exp_cnt = 8'd0;
    logic       exp_err = 1'b0;

    capture_ctrl #(.AW(AW), .DW(DW), .NPIX(NPIX)) dut (
        .PCLK       (PCLK),
        .rst        (rst),
        .VSYNC      (VSYNC),
        .start      (start),
        .stop       (stop),
        .mode_cont  (mode_cont),
        .clr_req    (clr_req),
        .clr_color  (clr_color),
        .cam_px_wr  (cam_px_wr),
        .cam_px_addr(cam_px_addr),
        .cam_px_data(cam_px_data),
        .fb_wr      (fb_wr),
        .fb_addr    (fb_addr),
        .fb_data    (fb_data),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt),
        .frame_err  (frame_err)
    );

    always #5 PCLK = ~PCLK;

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_cycle(input string tag, input logic e_wr, input logic [AW-1:0] e_addr,
                             input logic [DW-1:0] e_data, input logic e_busy, input logic e_done);
        chk($sformatf("%s.fb_wr", tag), 32'(fb_wr), 32'(e_wr));
        if (e_wr) begin
            chk($sformatf("%s.fb_addr", tag), 32'(fb_addr), 32'(e_addr));
            chk($sformatf("%s.fb_data", tag), 32'(fb_data), 32'(e_data));
        end
        chk($sformatf("%s.busy", tag), 32'(busy), 32'(e_busy));
        chk($sformatf("%s.frame_done", tag), 32'(frame_done), 32'(e_done));
        chk($sformatf("%s.frame_cnt", tag), 32'(frame_cnt), 32'(exp_cnt));
        chk($sformatf("%s.frame_err", tag), 32'(frame_err), 32'(exp_err));
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic rand_cam();
        cam_px_wr   = 1'($urandom_range(0, 1));
        cam_px_addr = AW'($urandom_range(0, 2**AW - 1));
        cam_px_data = DW'($urandom);
    endtask

    // Cycles in which no framebuffer write may appear.
    task automatic idle_cycles(input int n, input logic e_busy, input string tag);
        for (int i = 0; i < n; i++) begin
            rand_cam();
            tick();
            chk_cycle(tag, 1'b0, '0, '0, e_busy, 1'b0);
        end
    endtask

    task automatic start_capture(input logic mode);
        start     = 1'b1;
        mode_cont = mode;
        rand_cam();
        exp_err   = 1'b0;
        tick();
        start     = 1'b0;
        chk_cycle("start", 1'b0, '0, '0, 1'b1, 1'b0);
    endtask

    // One frame from VSYNC fall to VSYNC rise with exactly nacc accepted writes,
    // the last of which coincides with the rising edge.
    task automatic run_frame(input int nacc, input bit cont, input int stop_at);
        bit   stopped = 0;
        int   acc     = 0;
        int   k       = 0;
        logic ew;
        VSYNC = 1'b0;
        rand_cam();
        tick();
        chk_cycle("vs_fall_blocked", 1'b0, '0, '0, 1'b1, 1'b0);
        while (acc < nacc - 1) begin
            cam_px_wr = ($urandom_range(0, 15) != 0);
            if (k == 0)
                cam_px_addr = AW'(NPIX);
            else if ($urandom_range(0, 31) == 0)
                cam_px_addr = AW'($urandom_range(NPIX, 2**AW - 1));
            else
                cam_px_addr = AW'(acc);
            cam_px_data = DW'($urandom);
            stop        = (k == stop_at);
            start       = ($urandom_range(0, 15) == 0);
            mode_cont   = 1'($urandom_range(0, 1));
            if (stop) stopped = 1;
            ew = cam_px_wr && (int'(cam_px_addr) < NPIX);
            tick();
            chk_cycle("capture", ew, cam_px_addr, cam_px_data, 1'b1, 1'b0);
            if (ew) acc++;
            k++;
        end
        stop        = 1'b0;
        start       = 1'b0;
        VSYNC       = 1'b1;
        cam_px_wr   = 1'b1;
        cam_px_addr = AW'(NPIX - 1);
        cam_px_data = DW'($urandom);
        exp_cnt++;
`ifdef CAPTURE_CTRL_FRAMECHK_EN
        if (acc + 1 != NPIX) exp_err = 1'b1;
`endif
        tick();
        chk_cycle("vs_rise", 1'b1, cam_px_addr, cam_px_data, cont && !stopped, 1'b1);
        rand_cam();
        tick();
        chk_cycle("after_rise", 1'b0, '0, '0, cont && !stopped, 1'b0);
    endtask

    initial begin
        rst       = 1'b1;
        VSYNC     = 1'b1;
        start     = 1'b0;
        stop      = 1'b0;
        mode_cont = 1'b0;
        clr_req   = 1'b0;
        clr_color = '0;
        rand_cam();
        tick();
        tick();
        chk_cycle("reset", 1'b0, '0, '0, 1'b0, 1'b0);
        chk("reset.fb_addr", 32'(fb_addr), 32'd0);
        chk("reset.fb_data", 32'(fb_data), 32'd0);
        rst = 1'b0;
        idle_cycles(4, 1'b0, "idle");

        // Clear with a simultaneous start, which must be dropped.
        clr_req   = 1'b1;
        start     = 1'b1;
        mode_cont = 1'b1;
        clr_color = 3'b101;
        rand_cam();
        tick();
        chk_cycle("clr_accept", 1'b0, '0, '0, 1'b1, 1'b0);
        for (int i = 0; i < NPIX; i++) begin
            rand_cam();
            clr_color = DW'($urandom);
            start     = ($urandom_range(0, 63) == 0);
            stop      = ($urandom_range(0, 63) == 0);
            clr_req   = ($urandom_range(0, 63) == 0);
            tick();
            chk_cycle("clear", 1'b1, AW'(i), 3'b101, 1'b1, 1'b0);
        end
        start   = 1'b0;
        stop    = 1'b0;
        clr_req = 1'b0;
        rand_cam();
        tick();
        chk_cycle("clear_end", 1'b0, '0, '0, 1'b0, 1'b0);
        idle_cycles(5, 1'b0, "after_clear");

        // Single full frame.
        start_capture(1'b0);
        idle_cycles(3, 1'b1, "wait_vs");
        run_frame(NPIX, 0, -1);
        idle_cycles(3, 1'b0, "single_done");

        // Stop while waiting for the frame start.
        start_capture(1'b1);
        idle_cycles(2, 1'b1, "wait_vs");
        stop = 1'b1;
        rand_cam();
        tick();
        stop = 1'b0;
        chk_cycle("stop_wait", 1'b0, '0, '0, 1'b0, 1'b0);
        VSYNC = 1'b0;
        idle_cycles(3, 1'b0, "no_frame_lo");
        VSYNC = 1'b1;
        idle_cycles(3, 1'b0, "no_frame_hi");

        // Continuous capture of three frames, stop requested in the third.
        start_capture(1'b1);
        idle_cycles(2, 1'b1, "wait_vs");
        run_frame($urandom_range(4, 40), 1, -1);
        run_frame($urandom_range(4, 40), 1, -1);
        run_frame($urandom_range(4, 40), 1, 1);
        idle_cycles(3, 1'b0, "cont_done");

        // Short frame by one pixel, then a new start clears the error.
        start_capture(1'b0);
        run_frame(NPIX - 1, 0, -1);
        idle_cycles(3, 1'b0, "err_hold");
        start_capture(1'b0);
        run_frame($urandom_range(5, 20), 0, -1);
        idle_cycles(2, 1'b0, "short_done");

        // Frame counter wrap.
        start_capture(1'b1);
        while (exp_cnt != 8'd255) run_frame($urandom_range(1, 4), 1, -1);
        run_frame(4, 1, 1);
        chk("wrap.frame_cnt", 32'(frame_cnt), 32'd0);
        idle_cycles(2, 1'b0, "wrap_done");

        // Reset in the middle of a capture with the camera strobe active.
        start_capture(1'b1);
        VSYNC = 1'b0;
        rand_cam();
        tick();
        chk_cycle("rst_vs_fall", 1'b0, '0, '0, 1'b1, 1'b0);
        cam_px_wr   = 1'b1;
        cam_px_addr = AW'(5);
        cam_px_data = 3'b011;
        tick();
        chk_cycle("rst_pre", 1'b1, AW'(5), 3'b011, 1'b1, 1'b0);
        cam_px_addr = AW'(7);
        #2;
        rst     = 1'b1;
        #1;
        exp_cnt = 8'd0;
        exp_err = 1'b0;
        chk_cycle("rst_async", 1'b0, '0, '0, 1'b0, 1'b0);
        chk("rst_async.fb_addr", 32'(fb_addr), 32'd0);
        chk("rst_async.fb_data", 32'(fb_data), 32'd0);
        tick();
        chk_cycle("rst_held", 1'b0, '0, '0, 1'b0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            VSYNC     = 1'($urandom_range(0, 1));
            cam_px_wr = 1'b1;
            cam_px_addr = AW'($urandom_range(0, NPIX - 1));
            tick();
            chk_cycle("post_rst", 1'b0, '0, '0, 1'b0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/capture_ctrl.md
# capture_ctrl

Sequencing and arbitration controller for the QQVGA framebuffer write port. Sits between the camera pixel-packing stage and the framebuffer memory: it decides when camera pixel writes are allowed through (single-shot or continuous capture, aligned to VSYNC frame boundaries), and owns the port during a framebuffer clear, filling all pixels with a constant colour. It also reports busy, frame completion, a frame counter and an optional pixel-count error flag.

## Interface
Parameters:
- `AW`, 15, framebuffer address width
- `DW`, 3, pixel data width (RGB111)
- `NPIX`, 19200, pixels per frame (160x120)

Ports:
- `PCLK` in 1: single clock, camera pixel clock; all logic on rising edge
- `rst` in 1: asynchronous, active-high reset
- `VSYNC` in 1: camera vertical sync, high between frames
- `start` in 1: capture request, one-cycle pulse
- `stop` in 1: end continuous capture after current frame, pulse
- `mode_cont` in 1: 1 = continuous capture, 0 = single frame; sampled at `start`
- `clr_req` in 1: clear request, pulse
- `clr_color` in DW: clear fill colour, sampled at `clr_req`
- `cam_px_wr` in 1: camera writer strobe
- `cam_px_addr` in AW: camera writer address
- `cam_px_data` in DW: camera writer data
- `fb_wr` out 1: framebuffer write enable
- `fb_addr` out AW: framebuffer address
- `fb_data` out DW: framebuffer data
- `busy` out 1: high in any state other than IDLE
- `frame_done` out 1: one-cycle pulse at end of each captured frame
- `frame_cnt` out 8: captured frames since reset, wraps 255 -> 0
- `frame_err` out 1: sticky pixel-count mismatch (only with macro)

## Operation
- Edge detect: `vs_q` <= `VSYNC`; `vs_fall` = `vs_q & ~VSYNC` (frame start), `vs_rise` = `~vs_q & VSYNC` (frame end).
- States: IDLE, CLEAR, WAIT_VS, CAPTURE.
- IDLE: `fb_wr`=0. `clr_req` -> CLEAR (latch `clr_color`, clear address counter = 0). Else `start` -> WAIT_VS (latch `mode_cont`, clear stop flag). `clr_req` wins over simultaneous `start`; `start` is dropped.
- CLEAR: one write per cycle, address 0..NPIX-1, data = latched colour; after address NPIX-1 is issued -> IDLE. Camera strobes ignored. `start`/`clr_req`/`stop` ignored.
- WAIT_VS: `vs_fall` -> CAPTURE. `stop` -> IDLE immediately.
- CAPTURE: `cam_px_*` passed through to `fb_*`; writes with `cam_px_addr` >= NPIX are dropped (`fb_wr`=0). `stop` sets stop flag. On `vs_rise`: pulse `frame_done`, `frame_cnt`+1; if continuous and stop flag clear -> WAIT_VS, else -> IDLE.
- Camera strobes outside CAPTURE never reach the framebuffer.
- `start` while busy ignored; `stop` outside WAIT_VS/CAPTURE ignored.
- Frame counter wraps modulo 256, no saturation.

## Timing
- Reset values: state IDLE, `fb_wr`=0, `fb_addr`=0, `fb_data`=0, `busy`=0, `frame_done`=0, `frame_cnt`=0, `frame_err`=0, `vs_q`=0, stop flag 0.
- All outputs registered. Pass-through latency: `cam_px_*` at edge n appears on `fb_*` after edge n+1.
- `clr_req` at edge n: first clear write (addr 0) on `fb_*` after edge n+2; last (addr NPIX-1) NPIX-1 cycles later; `busy` falls the cycle after the last write.
- `frame_done` and `frame_cnt` update on the cycle after the `vs_rise` edge detection; a camera strobe coincident with `vs_rise` is still written.
- `busy` reflects registered state (one cycle after the triggering pulse).
- Reset asserted mid-clear or mid-capture: immediate return to reset values; no partial state retained.

## Configuration
- `CAPTURE_CTRL_FRAMECHK_EN` defined: a pixel counter (AW+1 bits) counts accepted camera writes in CAPTURE. At `vs_rise`, if count != NPIX, `frame_err` is set. Sticky; cleared only by an accepted `start` or reset.
- Not defined: counter omitted, `frame_err` tied to 0.

## Test plan
- Reset mid-CAPTURE with `cam_px_wr`=1 -> all outputs 0 next cycle, `busy`=0, no further `fb_wr`.
- `clr_req`, `clr_color`=3'b101 -> exactly 19200 writes, addresses 0..19199 consecutive, data 101, then `busy`=0; simultaneous `start` has no effect.
- Single capture: `start`, `mode_cont`=0; strobes before `vs_fall` blocked; 19200 strobes forwarded with 1-cycle latency; `vs_rise` -> one `frame_done`, `frame_cnt`=1, IDLE.
- Continuous: 3 frames captured, `stop` pulsed in the third -> 3 `frame_done` pulses, `frame_cnt`=3, IDLE after the third frame end; `stop` in WAIT_VS -> IDLE with no further frame.
- Boundary: `cam_px_addr`=19200 -> `fb_wr` stays 0; 256 frames -> `frame_cnt` wraps to 0.
- With `CAPTURE_CTRL_FRAMECHK_EN`: frame of 19199 strobes -> `frame_err`=1, stays 1 through next frame until `start`; frame of 19200 -> stays 0.
